// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an asynchronous PWM input in clk cycles and reports the period,
//   high time and integer duty percentage floor(high*100/period) (0..100).
//
//   Ports
//     clk         system clock, all logic on rising edge
//     rst_n       asynchronous active-low reset
//     pwm_in      PWM input, asynchronous to clk
//     period_cnt  last measured period (cycles), 0 after a stuck event
//     high_cnt    last measured high time (cycles), 0 after a stuck event
//     duty_pct    floor(high_cnt*100/period_cnt); 100/0 after a stuck event
//     valid       one-cycle pulse: period_cnt/high_cnt/duty_pct updated in the
//                 same cycle; there is no back-pressure, a consumer must take
//                 the result while valid is high
//     stuck       level, high while no rising edge for MAX_PERIOD cycles
//     overrun     one-cycle pulse, a period was dropped (divider busy)
//     dbg_state   current FSM state (0 IDLE, 1 MEASURE, 2 DIVIDE)
module pwm_capture #(
   parameter int CNT_W      = 16,
   parameter int MAX_PERIOD = 4000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_cnt,
   output logic [CNT_W-1:0] high_cnt,
   output logic [7:0]       duty_pct,
   output logic             valid,
   output logic             stuck,
   output logic             overrun,
   output logic [1:0]       dbg_state
);

   // Numerator width: high*100 needs CNT_W+7 bits.
   localparam int NW = CNT_W + 7;
   localparam int IW = $clog2(NW + 1);

   localparam logic [CNT_W-1:0] MAXP      = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [IW-1:0]    LAST_ITER = IW'(NW);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DIVIDE  = 2'd2
   } state_t;

   state_t           state;
   logic             sync_q;
   logic             s;
   logic             s_d;
   logic [CNT_W-1:0] pcnt;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] cap_p;
   logic [CNT_W-1:0] cap_h;
   // num holds the numerator; quotient bits shift in at the bottom as the
   // numerator bits shift out of the top, so it ends up holding the quotient.
   logic [NW-1:0]    num;
   logic [CNT_W-1:0] rem;
   logic [IW-1:0]    iter;

   logic             rise;
   logic [CNT_W-1:0] p_inc;
   logic [CNT_W-1:0] h_inc;
   logic [NW-1:0]    h_ext;
   logic [NW-1:0]    num_init;
   logic [CNT_W:0]   trial;
   logic [CNT_W:0]   divisor;
   logic [CNT_W:0]   diff;
   logic             fits;

   assign rise = s & ~s_d;

   // Saturating counters: they never wrap past MAX_PERIOD.
   assign p_inc = (pcnt == MAXP) ? pcnt : pcnt + ONE;
   assign h_inc = (s && (hcnt != MAXP)) ? hcnt + ONE : hcnt;

   // hcnt*100 as 64+32+4 to keep every term at NW bits.
   assign h_ext    = NW'(hcnt);
   assign num_init = (h_ext << 6) + (h_ext << 5) + (h_ext << 2);

   // One restoring-division step. rem < divisor always, so the shifted
   // trial remainder fits in CNT_W+1 bits and the difference in CNT_W.
   assign trial   = {rem, num[NW-1]};
   assign divisor = {1'b0, cap_p};
   assign fits    = (trial >= divisor);
   assign diff    = trial - divisor;

   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 1'b0;
         s          <= 1'b0;
         s_d        <= 1'b0;
         state      <= IDLE;
         pcnt       <= '0;
         hcnt       <= '0;
         cap_p      <= '0;
         cap_h      <= '0;
         num        <= '0;
         rem        <= '0;
         iter       <= '0;
         period_cnt <= '0;
         high_cnt   <= '0;
         duty_pct   <= '0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sync_q  <= pwm_in;
         s       <= sync_q;
         s_d     <= s;
         valid   <= 1'b0;
         overrun <= 1'b0;

         unique case (state)
            IDLE: begin
               // No result for the first rise: it only opens a period.
               hcnt <= '0;
               if (rise) begin
                  pcnt  <= ONE;
                  hcnt  <= ONE;
                  stuck <= 1'b0;
                  state <= MEASURE;
               end else begin
                  pcnt <= p_inc;
                  if (p_inc == MAXP) stuck <= 1'b1;
               end
            end

            MEASURE: begin
               if (rise) begin
                  // Capture the values before this cycle's increment.
                  cap_p <= pcnt;
                  cap_h <= hcnt;
                  num   <= num_init;
                  rem   <= '0;
                  iter  <= '0;
                  pcnt  <= ONE;
                  hcnt  <= ONE;
                  state <= DIVIDE;
               end else if (pcnt == MAXP) begin
                  // Input stuck: report the level it is stuck at.
                  period_cnt <= '0;
                  high_cnt   <= '0;
                  duty_pct   <= s ? 8'd100 : 8'd0;
                  valid      <= 1'b1;
                  stuck      <= 1'b1;
                  hcnt       <= '0;
                  state      <= IDLE;
               end else begin
                  pcnt <= p_inc;
                  hcnt <= h_inc;
               end
            end

            DIVIDE: begin
               // Counters keep measuring the next period; a rise here
               // drops that period but the running divide finishes.
               if (rise) begin
                  pcnt    <= ONE;
                  hcnt    <= ONE;
                  overrun <= 1'b1;
               end else begin
                  pcnt <= p_inc;
                  hcnt <= h_inc;
               end

               if (iter != LAST_ITER) begin
                  rem  <= fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
                  num  <= {num[NW-2:0], fits};
                  iter <= iter + IW'(1);
               end else begin
                  period_cnt <= cap_p;
                  high_cnt   <= cap_h;
                  duty_pct   <= num[7:0];
                  valid      <= 1'b1;
                  state      <= MEASURE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
